pipearch_s2v_arbiter: RTL and testbench

PIPEARCH_S2V_ARBITER -- requirements
Module: pipearch_s2v_arbiter

---
 rtl/pipearch_s2v_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipearch_s2v_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipearch_s2v_arbiter.sv
// pipearch_s2v_arbiter: round-robin scalar-to-vector arbiter.
// Hands the packer's scalar input port to one requester at a time. The owner
// streams job_len scalars, and a partial line is closed with a single
// out_flush. A job_done pulse returns ownership.
// Optional build macro PIPEARCH_S2V_ARB_WATCHDOG_EN adds a stall watchdog.
// That watchdog aborts a job starved of input for 1023 cycles and reports
// the abort on watchdog_err.
//
// state  | meaning
// IDLE   | no owner; picks the next requester round-robin
// STREAM | owner moves scalars to the packer when out_ready allows
// FLUSH  | one out_flush cycle, after the last scalar left, to close a partial line
// DONE   | job_done to the owner; the owner becomes the round-robin reference

module pipearch_s2v_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LINE_WORDS = 16,
    parameter int LEN_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       job_req,
    input  logic [NUM_REQ*LEN_W-1:0] job_len,
    input  logic [NUM_REQ-1:0]       in_valid,
    input  logic [NUM_REQ*32-1:0]    in_data,
    output logic [NUM_REQ-1:0]       in_ready,
    input  logic                     out_ready,
    output logic                     out_rvalid,
    output logic [31:0]              out_rdata,
    output logic                     out_flush,
    output logic [NUM_REQ-1:0]       job_done,
    output logic [2:0]               grant_id,
    output logic                     busy
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
    ,
    output logic                     watchdog_err
`endif
);

    localparam int WC_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       last_grant_q, last_grant_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WC_W-1:0]  wc_q, wc_d;
    logic             out_rvalid_q, out_rvalid_d;
    logic [31:0]      out_rdata_q, out_rdata_d;
    logic             out_flush_q, out_flush_d;
    logic [NUM_REQ-1:0] job_done_q, job_done_d;

    // Per-requester inputs are padded out to 8 entries so that a 3-bit
    // owner index can select them for any NUM_REQ.
    logic [7:0]       req_pad;
    logic [7:0]       valid_pad;
    logic [LEN_W-1:0] len_arr [8];
    logic [31:0]      data_arr [8];

    logic [2:0]       rr_pick;
    logic             rr_found;
    logic [3:0]       cand;

    logic             xfer;
    logic [WC_W-1:0]  wc_inc;
    logic [7:0]       rdy8;
    logic [7:0]       done8;

`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
    logic [9:0]       idle_q, idle_d;
    logic             wd_hit_q, wd_hit_d;
    logic             wd_err_q, wd_err_d;
`endif

    // Unpack the flat per-requester buses into indexable arrays.
    always_comb begin
        req_pad   = '0;
        valid_pad = '0;
        for (int i = 0; i < 8; i++) begin
            len_arr[i]  = '0;
            data_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pad[i]   = job_req[i];
            valid_pad[i] = in_valid[i];
            len_arr[i]   = job_len[i*LEN_W +: LEN_W];
            data_arr[i]  = in_data[i*32 +: 32];
        end
    end

    // Round-robin pick: the first requester after the last owner, wrapping mod NUM_REQ.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant_q} + 4'(i);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!rr_found && req_pad[cand[2:0]]) begin
                rr_found = 1'b1;
                rr_pick  = cand[2:0];
            end
        end
    end

    // Only the owner sees out_ready, and only while streaming.
    always_comb begin
        rdy8 = '0;
        if (state_q == S_STREAM) begin
            rdy8[grant_q] = out_ready;
        end
        in_ready = rdy8[NUM_REQ-1:0];
        busy     = (state_q != S_IDLE);
        grant_id = grant_q;
        xfer     = (state_q == S_STREAM) && out_ready && valid_pad[grant_q];
        wc_inc   = (wc_q == WC_W'(LINE_WORDS - 1)) ? '0 : wc_q + WC_W'(1);
    end

    // Next-state logic for the controller and its registered outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rem_d        = rem_q;
        wc_d         = wc_q;
        out_rvalid_d = xfer;
        out_rdata_d  = xfer ? data_arr[grant_q] : out_rdata_q;
        out_flush_d  = 1'b0;
        done8        = '0;
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
        idle_d       = idle_q;
        wd_hit_d     = wd_hit_q;
        wd_err_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    rem_d   = len_arr[rr_pick];
                    wc_d    = '0;
                    state_d = (len_arr[rr_pick] == '0) ? S_DONE : S_STREAM;
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
                    idle_d   = '0;
                    wd_hit_d = 1'b0;
`endif
                end
            end

            S_STREAM: begin
                if (xfer) begin
                    rem_d = rem_q - LEN_W'(1);
                    wc_d  = wc_inc;
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
                    idle_d = '0;
`endif
                    if (rem_q == LEN_W'(1)) begin
                        // A line that ends exactly on a boundary needs no flush.
                        state_d = (wc_inc != '0) ? S_FLUSH : S_DONE;
                    end
                end
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
                else if (idle_q == 10'h3FF) begin
                    wd_hit_d = 1'b1;
                    state_d  = (wc_q != '0) ? S_FLUSH : S_DONE;
                end
                else begin
                    idle_d = idle_q + 10'd1;
                end
`endif
            end

            S_FLUSH: begin
                // The flush is registered, so it lands one cycle after the last out_rvalid.
                out_flush_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                done8[grant_q] = 1'b1;
                last_grant_d   = grant_q;
                state_d        = S_IDLE;
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
                wd_err_d = wd_hit_q;
                wd_hit_d = 1'b0;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        job_done_d = done8[NUM_REQ-1:0];
    end

    // Controller state and output registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 3'(NUM_REQ - 1);
            rem_q        <= '0;
            wc_q         <= '0;
            out_rvalid_q <= 1'b0;
            out_rdata_q  <= '0;
            out_flush_q  <= 1'b0;
            job_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rem_q        <= rem_d;
            wc_q         <= wc_d;
            out_rvalid_q <= out_rvalid_d;
            out_rdata_q  <= out_rdata_d;
            out_flush_q  <= out_flush_d;
            job_done_q   <= job_done_d;
        end
    end

`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
    // Stall watchdog registers; the error pulse is aligned with job_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q   <= '0;
            wd_hit_q <= 1'b0;
            wd_err_q <= 1'b0;
        end else begin
            idle_q   <= idle_d;
            wd_hit_q <= wd_hit_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign watchdog_err = wd_err_q;
`endif

    assign out_rvalid = out_rvalid_q;
    assign out_rdata  = out_rdata_q;
    assign out_flush  = out_flush_q;
    assign job_done   = job_done_q;

endmodule

// File: tb/tb_pipearch_s2v_arbiter.sv
// Testbench for pipearch_s2v_arbiter. A transaction-level model computes the
// expected grant order, the concatenated scalar stream, the flush count and
// the job completions. These expectations are compared against what the DUT
// produces.

module tb_pipearch_s2v_arbiter;

    localparam int NR   = 4;
    localparam int LW   = 16;
    localparam int LENW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     job_req;
    logic [NR*LENW-1:0] job_len;
    logic [NR-1:0]     in_valid;
    logic [NR*32-1:0]  in_data;
    logic [NR-1:0]     in_ready;
    logic              out_ready;
    logic              out_rvalid;
    logic [31:0]       out_rdata;
    logic              out_flush;
    logic [NR-1:0]     job_done;
    logic [2:0]        grant_id;
    logic              busy;
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
    logic              watchdog_err;
`endif

    always #5 clk = ~clk;

    pipearch_s2v_arbiter #(.NUM_REQ(NR), .LINE_WORDS(LW), .LEN_W(LENW)) dut (
        .clk(clk), .reset(reset), .job_req(job_req), .job_len(job_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
        .out_flush(out_flush), .job_done(job_done), .grant_id(grant_id),
        .busy(busy)
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
        , .watchdog_err(watchdog_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    // requester-side model state
    int          model_last;
    int          len_cfg [NR];
    logic [31:0] mem [NR][64];
    int          ptr [NR];
    int          vmode, rmode, valid_limit, drop_early;
    logic        tog;

    // expectations
    int          exp_order[$];
    logic [31:0] exp_data[$];
    int          exp_flush;

    // observations
    logic [31:0] obs_q[$];
    int          rv_cyc[$];
    int          fl_cyc[$];
    int          done_cyc[$];
    int          done_id[$];
    int          grant_seen[$];
    int          wd_cyc[$];
    int          overlap, mirror_bad, coincide, xfer_cnt, cyc;
    logic        busy_prev;

    task automatic clear_obs();
        obs_q.delete(); rv_cyc.delete(); fl_cyc.delete(); done_cyc.delete();
        done_id.delete(); grant_seen.delete(); wd_cyc.delete();
        overlap = 0; mirror_bad = 0; coincide = 0; xfer_cnt = 0;
        busy_prev = busy;
    endtask

    task automatic fill_job(input int r, input int len);
        len_cfg[r] = len;
        ptr[r] = 0;
        for (int i = 0; i < 64; i++) mem[r][i] = $urandom;
        job_len[r*LENW +: LENW] = LENW'(len);
        job_req[r] = 1'b1;
    endtask

    // Jobs all posted together are served cyclically starting after the last owner.
    task automatic build_expect(input logic [NR-1:0] mask);
        int id;
        exp_order.delete(); exp_data.delete(); exp_flush = 0;
        for (int k = 1; k <= NR; k++) begin
            id = (model_last + k) % NR;
            if (mask[id]) begin
                exp_order.push_back(id);
                for (int i = 0; i < len_cfg[id]; i++) exp_data.push_back(mem[id][i]);
                if (len_cfg[id] % LW != 0) exp_flush++;
            end
        end
        if (exp_order.size() > 0) model_last = exp_order[exp_order.size()-1];
    endtask

    function automatic int data_mism();
        int m = 0;
        if (obs_q.size() != exp_data.size()) return 1000 + obs_q.size();
        foreach (obs_q[i]) if (obs_q[i] !== exp_data[i]) m++;
        return m;
    endfunction

    function automatic int order_mism(input int got[$]);
        int m = 0;
        if (got.size() != exp_order.size()) return 1000 + got.size();
        foreach (got[i]) if (got[i] != exp_order[i]) m++;
        return m;
    endfunction

    task automatic run(input int max_cyc, input int want_dones, input int want_x, output bit ok);
        int  tail = -1;
        bit  v;
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (drop_early != 0 && busy) job_req = '0;
            tog = ~tog;
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
            for (int r = 0; r < NR; r++) begin
                v = (ptr[r] < len_cfg[r]) && (valid_limit < 0 || ptr[r] < valid_limit)
                    && (vmode == 0 || $urandom_range(0, 1) == 1);
                in_valid[r] = v;
                in_data[r*32 +: 32] = (ptr[r] < 64) ? mem[r][ptr[r]] : 32'h0;
            end
            #1;
            if ($countones(in_ready) > 1) overlap++;
            if (in_ready != '0 && !out_ready) mirror_bad++;
            for (int r = 0; r < NR; r++) begin
                if (in_valid[r] && in_ready[r]) begin
                    ptr[r]++;
                    xfer_cnt++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (out_rvalid) begin
                obs_q.push_back(out_rdata);
                rv_cyc.push_back(cyc);
            end
            if (out_flush) fl_cyc.push_back(cyc);
            if (out_flush && out_rvalid) coincide++;
            for (int r = 0; r < NR; r++) begin
                if (job_done[r]) begin
                    done_id.push_back(r);
                    done_cyc.push_back(cyc);
                    job_req[r] = 1'b0;
                end
            end
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
            if (watchdog_err) wd_cyc.push_back(cyc);
`endif
            if (busy && !busy_prev) grant_seen.push_back(int'(grant_id));
            busy_prev = busy;
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end else if (tail < 0 &&
                         ((want_dones > 0 && done_id.size() >= want_dones) ||
                          (want_x > 0 && xfer_cnt >= want_x))) begin
                ok = 1'b1;
                tail = (want_x > 0) ? 0 : 3;
                if (tail == 0) break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        job_req = '0; in_valid = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_last = NR - 1;
        for (int r = 0; r < NR; r++) begin
            ptr[r] = 0;
            len_cfg[r] = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (in_ready !== '0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (out_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", out_rvalid); end
        total++; if (out_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", out_flush); end
        total++; if (job_done !== '0) begin bad++; $display("FAIL reset_done got=%b exp=0", job_done); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        total++; if (out_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", out_rdata); end
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
        total++; if (watchdog_err !== 1'b0) begin bad++; $display("FAIL reset_wderr got=%0b exp=0", watchdog_err); end
`endif
    endtask

    task automatic test_full_line();
        bit ok;
        int m;
        clear_obs(); vmode = 0; rmode = 0;
        fill_job(0, 16);
        build_expect(4'b0001);
        run(100, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_timeout got=%0d dones exp=1", done_id.size()); end
        m = data_mism();
        total++; if (m != 0) begin bad++; $display("FAIL full_data got=%0d mismatches exp=0", m); end
        total++; if (rv_cyc.size() != 16 || rv_cyc[rv_cyc.size()-1] - rv_cyc[0] != 15) begin
            bad++; $display("FAIL full_consecutive got=%0d strobes exp=16 back-to-back", rv_cyc.size()); end
        total++; if (fl_cyc.size() != 0) begin bad++; $display("FAIL full_noflush got=%0d exp=0", fl_cyc.size()); end
        total++; if (done_id.size() != 1 || done_id[0] != 0) begin
            bad++; $display("FAIL full_done got=%0d pulses exp=1 on req0", done_id.size()); end
    endtask

    task automatic test_partial();
        bit ok;
        int m;
        clear_obs(); vmode = 0; rmode = 0;
        fill_job(1, 20);
        build_expect(4'b0010);
        run(100, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL partial_timeout got=%0d dones exp=1", done_id.size()); end
        m = data_mism();
        total++; if (m != 0) begin bad++; $display("FAIL partial_data got=%0d mismatches exp=0", m); end
        total++; if (fl_cyc.size() != 1) begin bad++; $display("FAIL partial_flushcnt got=%0d exp=1", fl_cyc.size()); end
        else begin
            total++; if (rv_cyc.size() == 0 || fl_cyc[0] != rv_cyc[rv_cyc.size()-1] + 1) begin
                bad++; $display("FAIL partial_flushpos got=%0d exp=last_rvalid+1", fl_cyc[0]); end
            total++; if (done_cyc.size() != 1 || done_cyc[0] != fl_cyc[0] + 1) begin
                bad++; $display("FAIL partial_donepos got=%0d dones exp=flush+1", done_cyc.size()); end
        end
        total++; if (done_id.size() != 1 || done_id[0] != 1) begin
            bad++; $display("FAIL partial_doneid got=%0d pulses exp=1 on req1", done_id.size()); end
    endtask

    task automatic test_all_four();
        bit ok;
        int m;
        do_reset();
        clear_obs(); vmode = 0; rmode = 0;
        for (int r = 0; r < NR; r++) fill_job(r, 4);
        build_expect(4'b1111);
        run(300, 4, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL four_timeout got=%0d dones exp=4", done_id.size()); end
        m = order_mism(grant_seen);
        total++; if (m != 0 || grant_seen[0] != 0) begin bad++; $display("FAIL four_grants got=%0d mismatches exp=0 (0,1,2,3)", m); end
        m = order_mism(done_id);
        total++; if (m != 0) begin bad++; $display("FAIL four_doneorder got=%0d mismatches exp=0", m); end
        total++; if (fl_cyc.size() != 4) begin bad++; $display("FAIL four_flushes got=%0d exp=4", fl_cyc.size()); end
        total++; if (overlap != 0) begin bad++; $display("FAIL four_overlap got=%0d exp=0", overlap); end
        m = data_mism();
        total++; if (m != 0) begin bad++; $display("FAIL four_data got=%0d mismatches exp=0", m); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int m;
        clear_obs(); vmode = 0; rmode = 1; drop_early = 1;
        fill_job(2, 8);
        build_expect(4'b0100);
        run(100, 1, 0, ok);
        drop_early = 0;
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d dones exp=1", done_id.size()); end
        total++; if (xfer_cnt != 8) begin bad++; $display("FAIL bp_xfers got=%0d exp=8", xfer_cnt); end
        total++; if (mirror_bad != 0) begin bad++; $display("FAIL bp_mirror got=%0d exp=0", mirror_bad); end
        m = data_mism();
        total++; if (m != 0) begin bad++; $display("FAIL bp_data got=%0d mismatches exp=0", m); end
        total++; if (fl_cyc.size() != 1 || coincide != 0) begin
            bad++; $display("FAIL bp_flush got=%0d exp=1", fl_cyc.size()); end
        total++; if (done_id.size() != 1 || done_id[0] != 2) begin
            bad++; $display("FAIL bp_done got=%0d pulses exp=1 on req2", done_id.size()); end
    endtask

    task automatic test_zero_len();
        bit ok;
        int c0;
        clear_obs(); vmode = 0; rmode = 0;
        fill_job(2, 0);
        build_expect(4'b0100);
        c0 = cyc;
        run(50, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=%0d dones exp=1", done_id.size()); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL zero_rvalid got=%0d exp=0", obs_q.size()); end
        total++; if (fl_cyc.size() != 0) begin bad++; $display("FAIL zero_flush got=%0d exp=0", fl_cyc.size()); end
        total++; if (done_cyc.size() != 1 || done_cyc[0] - c0 != 2 || done_id[0] != 2) begin
            bad++; $display("FAIL zero_done got=%0d pulses exp=1 on req2 two cycles after grant", done_cyc.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int m;
        logic [NR-1:0] mask;
        for (int it = 0; it < 6; it++) begin
            clear_obs(); vmode = 1; rmode = 2;
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int r = 0; r < NR; r++) begin
                len_cfg[r] = 0;
                if (mask[r]) fill_job(r, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40));
            end
            build_expect(mask);
            run(3000, $countones(mask), 0, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=%0d dones exp=%0d", it, done_id.size(), $countones(mask)); end
            m = data_mism();
            total++; if (m != 0) begin bad++; $display("FAIL rand%0d_data got=%0d mismatches exp=0", it, m); end
            m = order_mism(done_id);
            total++; if (m != 0) begin bad++; $display("FAIL rand%0d_order got=%0d mismatches exp=0", it, m); end
            total++; if (fl_cyc.size() != exp_flush) begin bad++; $display("FAIL rand%0d_flush got=%0d exp=%0d", it, fl_cyc.size(), exp_flush); end
            total++; if (overlap != 0 || coincide != 0 || mirror_bad != 0) begin
                bad++; $display("FAIL rand%0d_handshake got=%0d/%0d/%0d exp=0/0/0", it, overlap, coincide, mirror_bad); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int m;
        clear_obs(); vmode = 0; rmode = 0;
        fill_job(3, 10);
        exp_data.delete();
        for (int i = 0; i < 5; i++) exp_data.push_back(mem[3][i]);
        run(60, 0, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=%0d xfers exp=5", xfer_cnt); end
        m = data_mism();
        total++; if (m != 0) begin bad++; $display("FAIL rmid_data got=%0d mismatches exp=0", m); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if ({busy, out_rvalid, out_flush, job_done, in_ready, grant_id} !== '0 || out_rdata !== 32'h0) begin
            bad++; $display("FAIL rmid_outputs got=%b rdata=%h exp=0", {busy, out_rvalid, out_flush, job_done, in_ready, grant_id}, out_rdata); end
        @(negedge clk);
        reset = 1'b0;
        job_req = '0;
        model_last = NR - 1;
        for (int r = 0; r < NR; r++) begin ptr[r] = 0; len_cfg[r] = 0; end
        clear_obs();
        run(20, 1, 0, ok);
        total++; if (done_id.size() != 0 || fl_cyc.size() != 0 || obs_q.size() != 0) begin
            bad++; $display("FAIL rmid_after got=%0d dones %0d flushes exp=0", done_id.size(), fl_cyc.size()); end
    endtask

`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        do_reset();
        clear_obs(); vmode = 0; rmode = 0; valid_limit = 3;
        fill_job(0, 10);
        run(1300, 1, 0, ok);
        valid_limit = -1;
        total++; if (!ok) begin bad++; $display("FAIL wd_timeout got=%0d dones exp=1", done_id.size()); end
        total++; if (obs_q.size() != 3) begin bad++; $display("FAIL wd_scalars got=%0d exp=3", obs_q.size()); end
        total++; if (fl_cyc.size() != 1) begin bad++; $display("FAIL wd_flush got=%0d exp=1", fl_cyc.size()); end
        total++; if (wd_cyc.size() != 1 || done_cyc.size() != 1 || wd_cyc[0] != done_cyc[0]) begin
            bad++; $display("FAIL wd_err got=%0d pulses exp=1 with job_done", wd_cyc.size()); end
    endtask
`endif

    initial begin
        reset = 1'b1; job_req = '0; job_len = '0; in_valid = '0; in_data = '0;
        out_ready = 1'b0; tog = 1'b0; cyc = 0;
        vmode = 0; rmode = 0; valid_limit = -1; drop_early = 0;
        model_last = NR - 1;
        for (int r = 0; r < NR; r++) begin ptr[r] = 0; len_cfg[r] = 0; end
        test_reset();
        test_full_line();
        test_partial();
        test_all_four();
        test_backpressure();
        test_zero_len();
        test_random();
        test_reset_mid();
`ifdef PIPEARCH_S2V_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
